// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and packet constants for the ALU packet engine.
package alu_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hAD,
    OP_MUL  = 8'h88,
    OP_XOR  = 8'hB5
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_LOAD,
    ST_EXEC,
    ST_SEND,
    ST_ECHO,
    ST_DRAIN,
    ST_ERR
  } state_e;

  localparam int         HDR_BYTES = 4;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  function automatic logic is_arith_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: a start pulse launches WIDTH_P iterations,
// done_o is high in the last one with product_o already holding the low product bits.
module shift_add_mul #(
  parameter int WIDTH_P = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH_P-1:0] a_i,
  input  logic [WIDTH_P-1:0] b_i,
  output logic               done_o,
  output logic [WIDTH_P-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH_P + 1);

  logic [WIDTH_P-1:0] r_a;
  logic [WIDTH_P-1:0] r_b;
  logic [WIDTH_P-1:0] r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i) begin
      r_a    <= a_i;
      r_b    <= b_i;
      r_p    <= '0;
      r_cnt  <= CNT_W'(WIDTH_P);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_b[0]) r_p <= r_p + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // Last partial product is folded in combinationally so the result is ready with done
  assign done_o    = r_busy && (r_cnt == CNT_W'(1));
  assign product_o = r_p + (r_b[0] ? r_a : '0);

endmodule

// File: rtl/alu_packet_engine.sv
// Byte-stream packet engine: parses opcode/length headers, runs ADD/XOR/MUL over
// little-endian operands, echoes payloads, and reports malformed packets with 0xEE.
module alu_packet_engine
  import alu_pkg::*;
#(
  parameter int WIDTH_P = 32,
  parameter int LEN_W_P = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int NB   = WIDTH_P / 8;
  localparam int BI_W = $clog2(NB + 1);

  state_e             r_state;
  logic [7:0]         r_op;
  logic [7:0]         r_len_lo;
  logic [LEN_W_P-1:0] r_cnt;
  logic [BI_W-1:0]    r_bidx;
  logic [BI_W-1:0]    r_send_cnt;
  logic [WIDTH_P-1:0] r_operand;
  logic [WIDTH_P-1:0] r_pend;
  logic [WIDTH_P-1:0] r_acc;
  logic [WIDTH_P-1:0] r_shift;
  logic               r_pend_v;
  logic               r_first;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_err;

  logic               w_rx_fire;
  logic               w_tx_fire;
  logic [LEN_W_P-1:0] w_len;
  logic [LEN_W_P-1:0] w_payload;
  logic               w_arith_ok;
  logic               w_hdr_err;
  logic               w_err_go;
  logic [WIDTH_P-1:0] w_opnd_full;
  logic               w_last_byte;
  logic [WIDTH_P-1:0] w_pend_res;
  logic [WIDTH_P-1:0] w_mul_a;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [WIDTH_P-1:0] w_mul_p;
  logic               w_final_go;
  logic [WIDTH_P-1:0] w_final;

  function automatic logic [WIDTH_P-1:0] combine(input logic [7:0] op, input logic first,
                                                 input logic [WIDTH_P-1:0] acc,
                                                 input logic [WIDTH_P-1:0] opnd);
    if (first) return opnd;
    case (op)
      OP_ADD:  return acc + opnd;
      OP_XOR:  return acc ^ opnd;
      default: return opnd;
    endcase
  endfunction

  always_comb begin
    rx_ready_o = 1'b0;
    case (r_state)
      ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_LOAD, ST_DRAIN: rx_ready_o = 1'b1;
      ST_ECHO: rx_ready_o = (r_cnt != '0) && (!r_tx_valid || tx_ready_i);
      default: rx_ready_o = 1'b0;
    endcase
  end

  assign w_rx_fire   = rx_valid_i && rx_ready_o;
  assign w_tx_fire   = r_tx_valid && tx_ready_i;
  assign w_len       = LEN_W_P'({rx_data_i, r_len_lo});
  assign w_payload   = (w_len >= LEN_W_P'(HDR_BYTES)) ? (w_len - LEN_W_P'(HDR_BYTES)) : '0;
  assign w_arith_ok  = (w_payload != '0) && ((w_payload % LEN_W_P'(NB)) == '0);
  assign w_hdr_err   = (r_op == OP_ECHO) ? (w_len < LEN_W_P'(HDR_BYTES))
                                         : (!(is_arith_op(r_op) && w_arith_ok) && (w_payload == '0));
  assign w_err_go    = w_rx_fire && (((r_state == ST_LEN_HI) && w_hdr_err) ||
                                     ((r_state == ST_DRAIN) && (r_cnt == LEN_W_P'(1))));
  assign w_opnd_full = (r_operand >> 8) | (WIDTH_P'(rx_data_i) << (WIDTH_P - 8));
  assign w_last_byte = (r_bidx == BI_W'(NB - 1));
  assign w_pend_res  = combine(r_op, r_first, r_acc, r_pend);
  // A first MUL operand may still be pending when the second one completes
  assign w_mul_a     = r_pend_v ? r_pend : r_acc;
  assign w_mul_start = (r_state == ST_LOAD) && w_rx_fire && w_last_byte && (r_op == OP_MUL) &&
                       !(r_first && !r_pend_v);
  assign w_final_go  = ((r_state == ST_EXEC) && w_mul_done && (r_cnt == '0)) ||
                       ((r_state == ST_SEND) && r_pend_v);
  assign w_final     = (r_state == ST_EXEC) ? w_mul_p : w_pend_res;

  shift_add_mul #(.WIDTH_P(WIDTH_P)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_mul_start),
    .a_i       (w_mul_a),
    .b_i       (w_opnd_full),
    .done_o    (w_mul_done),
    .product_o (w_mul_p)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_len_lo   <= '0;
      r_cnt      <= '0;
      r_bidx     <= '0;
      r_send_cnt <= '0;
      r_operand  <= '0;
      r_pend     <= '0;
      r_acc      <= '0;
      r_shift    <= '0;
      r_pend_v   <= 1'b0;
      r_first    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_rx_fire) begin
          r_op    <= rx_data_i;
          r_state <= ST_RSVD;
        end
        ST_RSVD: if (w_rx_fire) r_state <= ST_LEN_LO;
        ST_LEN_LO: if (w_rx_fire) begin
          r_len_lo <= rx_data_i;
          r_state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (w_rx_fire) begin
          r_cnt    <= w_payload;
          r_bidx   <= '0;
          r_pend_v <= 1'b0;
          r_first  <= 1'b1;
          r_acc    <= '0;
          if (r_op == OP_ECHO)                       r_state <= (w_payload == '0) ? ST_IDLE : ST_ECHO;
          else if (is_arith_op(r_op) && w_arith_ok) r_state <= ST_LOAD;
          else                                       r_state <= ST_DRAIN;
        end
        ST_LOAD: begin
          if (r_pend_v) begin
            r_acc    <= w_pend_res;
            r_first  <= 1'b0;
            r_pend_v <= 1'b0;
          end
          if (w_rx_fire) begin
            r_cnt     <= r_cnt - LEN_W_P'(1);
            r_operand <= w_opnd_full;
            if (!w_last_byte) begin
              r_bidx <= r_bidx + BI_W'(1);
            end else begin
              r_bidx <= '0;
              if (w_mul_start) begin
                r_first  <= 1'b0;
                r_pend_v <= 1'b0;
                r_state  <= ST_EXEC;
              end else begin
                r_pend   <= w_opnd_full;
                r_pend_v <= 1'b1;
                if (r_cnt == LEN_W_P'(1)) r_state <= ST_SEND;
              end
            end
          end
        end
        ST_EXEC: if (w_mul_done) begin
          r_acc <= w_mul_p;
          if (r_cnt != '0) r_state <= ST_LOAD;
        end
        ST_SEND: if (!r_pend_v && w_tx_fire) begin
          if (r_send_cnt == '0) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tx_data  <= r_shift[7:0];
            r_shift    <= r_shift >> 8;
            r_send_cnt <= r_send_cnt - BI_W'(1);
          end
        end
        ST_ECHO: begin
          if (w_rx_fire) begin
            r_tx_data  <= rx_data_i;
            r_tx_valid <= 1'b1;
            r_cnt      <= r_cnt - LEN_W_P'(1);
          end else if ((r_cnt == '0) && (!r_tx_valid || tx_ready_i)) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
          end
        end
        ST_DRAIN: if (w_rx_fire) r_cnt <= r_cnt - LEN_W_P'(1);
        ST_ERR: if (w_tx_fire) begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Final result: load the first byte and queue the rest for serialisation
      if (w_final_go) begin
        r_acc      <= w_final;
        r_pend_v   <= 1'b0;
        r_tx_data  <= w_final[7:0];
        r_tx_valid <= 1'b1;
        r_shift    <= w_final >> 8;
        r_send_cnt <= BI_W'(NB - 1);
        r_state    <= ST_SEND;
      end

      if (w_err_go) begin
        r_state    <= ST_ERR;
        r_err      <= 1'b1;
        r_tx_data  <= ERR_BYTE;
        r_tx_valid <= 1'b1;
      end
    end
  end

  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = (r_state != ST_IDLE);
  assign err_o      = r_err;

endmodule

// File: doc/alu_packet_engine.md
ALU_PACKET_ENGINE -- requirements
Module: alu_packet_engine

Interface
REQ-001 SHALL have parameter WIDTH_P, default 32, operand/result width in bits; legal 8..64, multiple of 8.
REQ-002 SHALL have parameter LEN_W_P, default 16, width of the packet length field.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  rx byte valid.
- rx_ready_o  out  1  engine accepts rx byte.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx byte valid.
- tx_ready_i  in  1  transmitter accepts byte.
- busy_o  out  1  high whenever state is not IDLE.
- err_o  out  1  one-cycle pulse on packet error.

Function
REQ-004 SHALL transfer a byte on either stream only in a cycle where valid and ready are both high; tx_data_o/tx_valid_o SHALL hold stable until accepted.
REQ-005 SHALL parse packets as: opcode, reserved byte (ignored), length LSB, length MSB, then payload; length counts all packet bytes including the 4 header bytes.
REQ-006 SHALL support opcodes ECHO=0xEC, ADD=0xAD, MUL=0x88, XOR=0xB5.
REQ-007 SHALL implement states IDLE, RSVD, LEN_LO, LEN_HI, LOAD, EXEC, SEND, ECHO, DRAIN, ERR; IDLE->RSVD->LEN_LO->LEN_HI on each accepted byte.
REQ-008 After LEN_HI: ECHO opcode -> ECHO; ADD/MUL/XOR with valid length -> LOAD; otherwise -> DRAIN (or ERR directly if no payload remains).
REQ-009 Valid arithmetic length: (length-4) nonzero and a multiple of WIDTH_P/8; ECHO valid length: length >= 4 (length 4 returns to IDLE, no output).
REQ-010 LOAD SHALL assemble WIDTH_P/8 bytes little-endian; first operand loads accumulator; each subsequent operand combines: ADD sum mod 2^WIDTH_P, XOR bitwise, MUL low WIDTH_P bits of product.
REQ-011 ADD/XOR SHALL combine in the cycle after the final operand byte; MUL SHALL go to EXEC, use shift-add taking exactly WIDTH_P cycles, rx_ready_o low throughout.
REQ-012 After final operand combined, SHALL enter SEND and emit accumulator as WIDTH_P/8 bytes, LSB first, then return to IDLE.
REQ-013 ECHO SHALL forward each payload byte to tx via a one-byte register; rx_ready_o = !tx_valid_o || tx_ready_i; after length-4 bytes forwarded and drained, return to IDLE.
REQ-014 DRAIN SHALL accept and discard remaining payload bytes (rx_ready_o=1), then enter ERR.
REQ-015 ERR SHALL pulse err_o once and emit single byte 0xEE, then return to IDLE.
REQ-016 rx_ready_o SHALL be high in IDLE, RSVD, LEN_LO, LEN_HI, LOAD, DRAIN; low in EXEC, SEND, ERR.
REQ-017 Byte counter SHALL be LEN_W_P bits; length 0xFFFF SHALL be handled without wrap errors.
REQ-018 tx_valid_o SHALL be low outside SEND, ECHO, ERR.

Reset
REQ-019 On rst_i: state IDLE, accumulator and counters zero, rx_ready_o=1 on the following cycle, tx_valid_o=0, tx_data_o=0, busy_o=0, err_o=0.
REQ-020 Reset asserted mid-packet SHALL abandon the packet; first byte after reset is parsed as opcode.

Structure
REQ-021 Package alu_pkg SHALL hold the opcode enum, state enum, HDR_BYTES=4 and ERR_BYTE=0xEE.
REQ-022 Sequential multiply SHALL be sub-module shift_add_mul (start/done handshake, WIDTH_P parameter).

Verification
REQ-023 ADD, W=32: EC? no -- AD 00 0C 00, operands 0x00000005, 0xFFFFFFFE -> tx 03 00 00 00.
REQ-024 MUL, W=32: 88 00 0C 00, 0x00010000, 0x00010003 -> EXEC 32 cycles, tx 00 00 03 00.
REQ-025 ECHO: EC 00 07 00 41 42 43 with tx_ready_i toggling every cycle -> tx 41 42 43, no loss or duplication.
REQ-026 Bad length: AD 00 07 00 01 02 03 -> bytes drained, err_o pulse, tx EE.
REQ-027 Unknown opcode 0x11, length 5, one payload byte -> tx EE; next valid XOR packet B5 00 0C 00 0xF0F0F0F0, 0xFFFFFFFF -> tx 0F 0F 0F 0F.
REQ-028 Reset asserted after second operand byte of ADD -> outputs at reset values; subsequent full ADD packet returns correct sum.
